rv32_writeback: RTL and testbench
=================================

// Module: rv32_writeback
// PURPOSE
//  Final pipeline stage of the RV32 core: register write-back producer.
//  - Registers the memory-stage result and aligns/extends load data.
//  - Drives the register file write port (rd, write enable, value).
//  - Counts retired instructions.
//  - Optionally provides an operand bypass for the decode stage.
// PARAMETERS
//  INSTRET_WIDTH  64  width of retired-instruction counter
// PORTS
//  clk                 in   1   core clock, all state on rising edge
//  reset_n             in   1   asynchronous active-low reset
//  stall_in            in   1   hold stage contents this cycle
//  flush_in            in   1   squash instruction entering stage
//  valid_in            in   1   memory-stage instruction valid
//  rd_in               in   5   destination register index
//  rd_write_in         in   1   instruction writes rd
//  result_in           in   32  ALU/CSR result (non-load)
//  mem_read_in         in   1   instruction is a load
//  mem_width_in        in   2   00 byte, 01 half, 10 word, 11 word
//  mem_zero_extend_in  in   1   1 = LBU/LHU, 0 = sign extend
//  mem_addr_lo_in      in   2   load address bits [1:0]
//  mem_read_value_in   in   32  raw 32-bit load bus word
//  rd_out              out  5   register file write index
//  rd_writeback_out    out  1   register file write enable
//  rd_value_out        out  32  register file write data
//  valid_out           out  1   instruction retiring this cycle
//  instret_out         out  INSTRET_WIDTH  retired-instruction count
//  rs1_in, rs2_in      in   5   decode operand indices (bypass only)
//  rs1_bypass_out      out  1   rs1 hits in-flight write (bypass only)
//  rs2_bypass_out      out  1   rs2 hits in-flight write (bypass only)
// BEHAVIOUR
//  Reset
//  - Asserting reset_n low immediately clears every registered output to 0,
//    including instret_out, independent of clk.
//  - Reset mid-instruction drops that write; there is no partial write.
//  Latency and control
//  - Single-cycle latency: inputs sampled at edge N appear on outputs after N.
//  - Priority: flush_in > stall_in > load.
//    - flush: valid_out=0, rd_writeback_out=0; rd_out and rd_value_out are don't-care.
//    - stall (no flush): all outputs hold their value.
//    - otherwise: the stage loads.
//  - rd_writeback_out is loaded with valid_in & rd_write_in & (rd_in!=0).
//    Writes to x0 are never issued.
//  Load alignment
//  - Applied when mem_read_in=1; otherwise rd_value_out=result_in.
//  - byte: lane mem_addr_lo_in selects bits [8*lo+7 : 8*lo].
//  - half: mem_addr_lo_in[1] selects the upper or lower 16 bits;
//    mem_addr_lo_in[0] is ignored (misalignment is trapped upstream).
//  - word: the value passes unchanged.
//  - Extension to 32 bits uses zero or sign per mem_zero_extend_in.
//  instret counter
//  - Increments by 1 on each edge where valid_in & !stall_in & !flush_in.
//  - Wraps modulo 2^INSTRET_WIDTH with no saturation or flag.
// CONFIGURATION
//  RV32_WB_BYPASS_EN defined
//  - rs1_in, rs2_in, rs1_bypass_out and rs2_bypass_out exist.
//  - rsN_bypass_out = rd_writeback_out & (rsN_in==rd_out), combinational.
//  - Decode muxes in rd_value_out, covering the register file write-then-read
//    gap.
//  RV32_WB_BYPASS_EN undefined
//  - These four ports are absent.
//  - The hazard unit stalls on read-after-write instead.
// TESTING
//  - Reset: reset_n=0 while outputs are nonzero -> all outputs 0 before the
//    next clk edge.
//  - ALU op: valid=1 rd=5 write=1 result=0xDEADBEEF -> next cycle
//    rd_out=5, writeback=1, value=0xDEADBEEF, instret+1.
//  - Loads with raw=0x80F1_7F82:
//    - LB lo=0 -> 0xFFFFFF82
//    - LBU lo=0 -> 0x00000082
//    - LB lo=1 -> 0x0000007F
//    - LH lo=2 -> 0xFFFF80F1
//    - LHU lo=2 -> 0x000080F1
//    - LW -> 0x80F17F82
//  - x0 and flush:
//    - rd=0 write=1 -> writeback=0, instret still +1.
//    - flush=1 with stall=1 -> valid=0, writeback=0, instret unchanged.
//  - Stall: 3 stall cycles -> outputs and instret held; the new instruction
//    lands on the cycle after stall drops.
//  - Wrap (INSTRET_WIDTH=4): 16 retirements -> instret returns to 0.
//  - Bypass (macro on): rd_out=7 writeback=1 rs1=7 rs2=8 ->
//    rs1_bypass=1, rs2_bypass=0.
//  - Bypass with writeback=0 -> both bypass outputs 0.

Source files
------------

// File: rtl/rv32_writeback.sv
// RV32 write-back stage: registers the memory-stage result, aligns/extends load data, counts retirements; 1-cycle latency.
// stall_in holds every output, flush_in squashes the incoming instruction; RV32_WB_BYPASS_EN adds decode operand bypass flags.
module rv32_writeback #(
    parameter int unsigned INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     stall_in,
    input  logic                     flush_in,
    input  logic                     valid_in,
    input  logic [4:0]               rd_in,
    input  logic                     rd_write_in,
    input  logic [31:0]              result_in,
    input  logic                     mem_read_in,
    input  logic [1:0]               mem_width_in,
    input  logic                     mem_zero_extend_in,
    input  logic [1:0]               mem_addr_lo_in,
    input  logic [31:0]              mem_read_value_in,
`ifdef RV32_WB_BYPASS_EN
    input  logic [4:0]               rs1_in,
    input  logic [4:0]               rs2_in,
    output logic                     rs1_bypass_out,
    output logic                     rs2_bypass_out,
`endif
    output logic [4:0]               rd_out,
    output logic                     rd_writeback_out,
    output logic [31:0]              rd_value_out,
    output logic                     valid_out,
    output logic [INSTRET_WIDTH-1:0] instret_out
);

    logic [4:0]               rd_q, rd_d;
    logic                     wb_q, wb_d;
    logic [31:0]              value_q, value_d;
    logic                     valid_q, valid_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_value;
    logic        retire;

    always_comb begin
        ld_byte = mem_read_value_in[7:0];
        case (mem_addr_lo_in)
            2'd0:    ld_byte = mem_read_value_in[7:0];
            2'd1:    ld_byte = mem_read_value_in[15:8];
            2'd2:    ld_byte = mem_read_value_in[23:16];
            default: ld_byte = mem_read_value_in[31:24];
        endcase
    end

    // Halfword lane uses only addr[1]; misaligned halves never reach this stage.
    assign ld_half = mem_addr_lo_in[1] ? mem_read_value_in[31:16] : mem_read_value_in[15:0];

    always_comb begin
        load_value = mem_read_value_in;
        case (mem_width_in)
            2'b00:   load_value = {{24{~mem_zero_extend_in & ld_byte[7]}}, ld_byte};
            2'b01:   load_value = {{16{~mem_zero_extend_in & ld_half[15]}}, ld_half};
            default: load_value = mem_read_value_in;
        endcase
    end

    assign retire = valid_in & ~stall_in & ~flush_in;

    always_comb begin
        rd_d      = rd_q;
        wb_d      = wb_q;
        value_d   = value_q;
        valid_d   = valid_q;
        instret_d = instret_q + INSTRET_WIDTH'(retire);
        if (flush_in) begin
            valid_d = 1'b0;
            wb_d    = 1'b0;
        end else if (!stall_in) begin
            valid_d = valid_in;
            wb_d    = valid_in & rd_write_in & (rd_in != 5'd0);
            rd_d    = rd_in;
            value_d = mem_read_in ? load_value : result_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= '0;
            wb_q      <= 1'b0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            rd_q      <= rd_d;
            wb_q      <= wb_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
        end
    end

    assign rd_out           = rd_q;
    assign rd_writeback_out = wb_q;
    assign rd_value_out     = value_q;
    assign valid_out        = valid_q;
    assign instret_out      = instret_q;

`ifdef RV32_WB_BYPASS_EN
    assign rs1_bypass_out = wb_q & (rs1_in == rd_q);
    assign rs2_bypass_out = wb_q & (rs2_in == rd_q);
`endif

endmodule

// File: tb/tb_rv32_writeback.sv
// Bench for rv32_writeback: directed spec vectors plus randomized traffic against a behavioural model.
module tb_rv32_writeback;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stall_in, flush_in, valid_in, rd_write_in, mem_read_in, mem_zero_extend_in;
    logic [4:0]    rd_in;
    logic [31:0]   result_in, mem_read_value_in;
    logic [1:0]    mem_width_in, mem_addr_lo_in;
    logic [4:0]    rd_out;
    logic          rd_writeback_out, valid_out;
    logic [31:0]   rd_value_out;
    logic [IW-1:0] instret_out;
`ifdef RV32_WB_BYPASS_EN
    logic [4:0]    rs1_in, rs2_in;
    logic          rs1_bypass_out, rs2_bypass_out;
`endif

    rv32_writeback #(.INSTRET_WIDTH(IW)) dut (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .rd_in(rd_in), .rd_write_in(rd_write_in), .result_in(result_in),
        .mem_read_in(mem_read_in), .mem_width_in(mem_width_in),
        .mem_zero_extend_in(mem_zero_extend_in), .mem_addr_lo_in(mem_addr_lo_in),
        .mem_read_value_in(mem_read_value_in),
`ifdef RV32_WB_BYPASS_EN
        .rs1_in(rs1_in), .rs2_in(rs2_in),
        .rs1_bypass_out(rs1_bypass_out), .rs2_bypass_out(rs2_bypass_out),
`endif
        .rd_out(rd_out), .rd_writeback_out(rd_writeback_out), .rd_value_out(rd_value_out),
        .valid_out(valid_out), .instret_out(instret_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference state: what the register-file port should show after each edge.
    logic        m_valid, m_wb, m_dc;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] w,
                                             input logic z, input logic [1:0] lo);
        longint unsigned v;
        if (w == 2'b00) begin
            v = (longint'(raw) >> (8 * lo)) % 256;
            if (!z && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (w == 2'b01) begin
            v = (longint'(raw) >> (16 * (lo / 2))) % 65536;
            if (!z && v >= 32768) v = v + 64'hFFFF_0000;
        end else begin
            v = longint'(raw);
        end
        return v[31:0];
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 64'(valid_out), 64'(m_valid));
        chk({tag, ".wb"}, 64'(rd_writeback_out), 64'(m_wb));
        chk({tag, ".instret"}, 64'(instret_out), 64'(m_cnt));
        if (!m_dc) begin
            chk({tag, ".rd"}, 64'(rd_out), 64'(m_rd));
            chk({tag, ".value"}, 64'(rd_value_out), 64'(m_val));
        end
`ifdef RV32_WB_BYPASS_EN
        chk({tag, ".byp1"}, 64'(rs1_bypass_out), 64'(m_wb && rs1_in == m_rd));
        chk({tag, ".byp2"}, 64'(rs2_bypass_out), 64'(m_wb && rs2_in == m_rd));
`endif
    endtask

    task automatic tick(input string tag);
        if (flush_in) begin
            m_valid = 1'b0;
            m_wb    = 1'b0;
            m_dc    = 1'b1;
        end else if (!stall_in) begin
            m_valid = valid_in;
            m_wb    = valid_in && rd_write_in && rd_in != 5'd0;
            m_rd    = rd_in;
            m_val   = mem_read_in ? ref_load(mem_read_value_in, mem_width_in, mem_zero_extend_in, mem_addr_lo_in)
                                  : result_in;
            m_dc    = 1'b0;
        end
        if (valid_in && !stall_in && !flush_in) m_cnt = (m_cnt + 1) % (1 << IW);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_inst(input logic v, input logic [4:0] rd, input logic wr, input logic [31:0] res,
                            input logic mr, input logic [1:0] w, input logic z, input logic [1:0] lo,
                            input logic [31:0] raw);
        valid_in = v; rd_in = rd; rd_write_in = wr; result_in = res;
        mem_read_in = mr; mem_width_in = w; mem_zero_extend_in = z;
        mem_addr_lo_in = lo; mem_read_value_in = raw;
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        m_valid = 0; m_wb = 0; m_rd = 0; m_val = 0; m_dc = 0; m_cnt = 0;
        #1;
        check_outputs("reset");
        chk("reset.value0", 64'(rd_value_out), 64'h0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        stall_in = 0; flush_in = 0;
        set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef RV32_WB_BYPASS_EN
        rs1_in = 0; rs2_in = 0;
`endif
        m_valid = 0; m_wb = 0; m_rd = 0; m_val = 0; m_dc = 0; m_cnt = 0;
        #2;
        check_outputs("por");
        reset_n = 1'b1;
        @(negedge clk);

        // ALU result, then asynchronous reset while outputs are nonzero
        set_inst(1, 5, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        tick("alu");
        chk("alu.value_const", 64'(rd_value_out), 64'hDEAD_BEEF);
        chk("alu.rd_const", 64'(rd_out), 64'd5);
        chk("alu.instret_const", 64'(instret_out), 64'd1);
        do_reset();

        // Load alignment vectors on raw word 0x80F17F82
        set_inst(1, 3, 1, 32'h1234_5678, 1, 2'b00, 0, 2'd0, 32'h80F1_7F82); tick("lb0");
        chk("lb0.const", 64'(rd_value_out), 64'hFFFF_FF82);
        set_inst(1, 3, 1, 32'h1234_5678, 1, 2'b00, 1, 2'd0, 32'h80F1_7F82); tick("lbu0");
        chk("lbu0.const", 64'(rd_value_out), 64'h0000_0082);
        set_inst(1, 3, 1, 32'h1234_5678, 1, 2'b00, 0, 2'd1, 32'h80F1_7F82); tick("lb1");
        chk("lb1.const", 64'(rd_value_out), 64'h0000_007F);
        set_inst(1, 3, 1, 32'h1234_5678, 1, 2'b01, 0, 2'd2, 32'h80F1_7F82); tick("lh2");
        chk("lh2.const", 64'(rd_value_out), 64'hFFFF_80F1);
        set_inst(1, 3, 1, 32'h1234_5678, 1, 2'b01, 1, 2'd2, 32'h80F1_7F82); tick("lhu2");
        chk("lhu2.const", 64'(rd_value_out), 64'h0000_80F1);
        set_inst(1, 3, 1, 32'h1234_5678, 1, 2'b10, 0, 2'd0, 32'h80F1_7F82); tick("lw");
        chk("lw.const", 64'(rd_value_out), 64'h80F1_7F82);

        // Write to x0 retires without a register write
        set_inst(1, 0, 1, 32'h0000_0011, 0, 0, 0, 0, 0); tick("x0");
        chk("x0.wb_const", 64'(rd_writeback_out), 64'd0);

        // Flush beats stall
        set_inst(1, 9, 1, 32'h0000_0099, 0, 0, 0, 0, 0);
        flush_in = 1; stall_in = 1; tick("flush_stall");
        flush_in = 0; stall_in = 0;

        // Three stall cycles hold everything, then the pending instruction lands
        set_inst(1, 7, 1, 32'hCAFE_0007, 0, 0, 0, 0, 0); tick("pre_stall");
        set_inst(1, 12, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
        stall_in = 1;
        for (int i = 0; i < 3; i++) tick("stall");
        chk("stall.value_const", 64'(rd_value_out), 64'hCAFE_0007);
        stall_in = 0; tick("post_stall");
        chk("post_stall.value_const", 64'(rd_value_out), 64'h0BAD_F00D);

`ifdef RV32_WB_BYPASS_EN
        set_inst(1, 7, 1, 32'h7, 0, 0, 0, 0, 0); tick("byp_setup");
        rs1_in = 7; rs2_in = 8; #1;
        chk("byp.rs1_const", 64'(rs1_bypass_out), 64'd1);
        chk("byp.rs2_const", 64'(rs2_bypass_out), 64'd0);
        set_inst(1, 7, 0, 32'h7, 0, 0, 0, 0, 0); tick("byp_nowb");
        chk("byp_nowb.rs1_const", 64'(rs1_bypass_out), 64'd0);
        chk("byp_nowb.rs2_const", 64'(rs2_bypass_out), 64'd0);
`endif

        // Counter wrap at 2^IW retirements from reset
        @(negedge clk);
        do_reset();
        for (int i = 0; i < (1 << IW); i++) begin
            set_inst(1, 5'(i + 1), 1, 32'(i), 0, 0, 0, 0, 0);
            tick("wrap");
        end
        chk("wrap.instret_zero", 64'(instret_out), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_inst(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom), $urandom,
                     1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), $urandom);
            stall_in = ($urandom_range(0, 4) == 0);
            flush_in = ($urandom_range(0, 9) == 0);
`ifdef RV32_WB_BYPASS_EN
            rs1_in = ($urandom_range(0, 1) == 0) ? rd_out : 5'($urandom);
            rs2_in = 5'($urandom);
`endif
            tick("rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
